// File: rtl/snake_body_streamer_if.sv
// Body-RAM port bundle between the snake body streamer (master) and the body RAM (slave).
`ifndef PIXEL_DISPLAY_BIT
`define PIXEL_DISPLAY_BIT 9
`endif

interface snake_body_streamer_if #(
    parameter int ADDR_W  = 7,
    parameter int COORD_W = 7
);
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_we;
    logic [COORD_W-1:0] mem_wdata_x;
    logic [COORD_W-1:0] mem_wdata_y;
    logic [COORD_W-1:0] mem_rdata_x;
    logic [COORD_W-1:0] mem_rdata_y;

    modport master (
        output mem_addr, mem_we, mem_wdata_x, mem_wdata_y,
        input  mem_rdata_x, mem_rdata_y
    );

    modport slave (
        input  mem_addr, mem_we, mem_wdata_x, mem_wdata_y,
        output mem_rdata_x, mem_rdata_y
    );
endinterface

// File: rtl/snake_body_streamer.sv
// Streams the snake body coordinates from body RAM once per frame, just after the game area,
// and arbitrates game-logic writes into the same RAM port while the stream is idle.
`ifndef PIXEL_DISPLAY_BIT
`define PIXEL_DISPLAY_BIT 9
`endif

module snake_body_streamer #(
    parameter int ADDR_W      = 7,
    parameter int COORD_W     = 7,
    parameter int STREAM_LINE = 449
) (
    input  logic                        clock_25,
    input  logic                        reset,
    input  logic [`PIXEL_DISPLAY_BIT:0] X,
    input  logic [`PIXEL_DISPLAY_BIT:0] Y,
    input  logic [ADDR_W-1:0]           snake_length,
    input  logic                        upd_req,
    input  logic [ADDR_W-1:0]           upd_addr,
    input  logic [COORD_W-1:0]          upd_x,
    input  logic [COORD_W-1:0]          upd_y,
    output logic                        upd_grant,
    snake_body_streamer_if.master       mem,
    output logic                        en_snake_body,
    output logic [COORD_W-1:0]          snake_body_x,
    output logic [COORD_W-1:0]          snake_body_y,
    output logic                        stream_busy,
    output logic                        frame_done
);

    localparam int XW = `PIXEL_DISPLAY_BIT + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state, state_n;
    logic [ADDR_W-1:0]  len_q, len_n;
    logic [ADDR_W-1:0]  addr_q, addr_n;
    logic               we_q, we_n;
    logic [COORD_W-1:0] wx_q, wx_n, wy_q, wy_n;
    logic               grant_q, grant_n;
    logic               pend_q, pend_n;
    logic               en_q, en_n;
    logic [COORD_W-1:0] bx_q, bx_n, by_q, by_n;
    logic               busy_q, busy_n;
    logic               done_q, done_n;
    logic               trigger;

    assign trigger = (X == XW'(799)) && (Y == XW'(STREAM_LINE));

    always_ff @(posedge clock_25) begin
        if (reset) begin
            state   <= IDLE;
            len_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wx_q    <= '0;
            wy_q    <= '0;
            grant_q <= 1'b0;
            pend_q  <= 1'b0;
            en_q    <= 1'b0;
            bx_q    <= '0;
            by_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            len_q   <= len_n;
            addr_q  <= addr_n;
            we_q    <= we_n;
            wx_q    <= wx_n;
            wy_q    <= wy_n;
            grant_q <= grant_n;
            pend_q  <= pend_n;
            en_q    <= en_n;
            bx_q    <= bx_n;
            by_q    <= by_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        len_n   = len_q;
        addr_n  = '0;
        we_n    = 1'b0;
        wx_n    = '0;
        wy_n    = '0;
        grant_n = 1'b0;
        pend_n  = 1'b0;

        case (state)
            IDLE: begin
                if (trigger) begin
                    len_n   = snake_length;
                    state_n = (snake_length == '0) ? DONE : READ;
                end else if (upd_req && !grant_q) begin
                    we_n    = 1'b1;
                    grant_n = 1'b1;
                    addr_n  = upd_addr;
                    wx_n    = upd_x;
                    wy_n    = upd_y;
                end
            end
            READ: begin
                pend_n = 1'b1;
                if (addr_q == len_q - ADDR_W'(1)) state_n = DRAIN;
                else                              addr_n  = addr_q + ADDR_W'(1);
            end
            DRAIN: begin
                // pend_q low means the last read data was already registered out
                if (!pend_q) state_n = DONE;
            end
            DONE: begin
                state_n = IDLE;
                // A write decided here lands in the following IDLE cycle, so it never overlaps busy
                if (upd_req && !grant_q) begin
                    we_n    = 1'b1;
                    grant_n = 1'b1;
                    addr_n  = upd_addr;
                    wx_n    = upd_x;
                    wy_n    = upd_y;
                end
            end
            default: state_n = IDLE;
        endcase

        en_n   = pend_q;
        bx_n   = pend_q ? mem.mem_rdata_x : '0;
        by_n   = pend_q ? mem.mem_rdata_y : '0;
        busy_n = (state_n != IDLE);
        done_n = (state_n == DONE);
    end

    assign mem.mem_addr    = addr_q;
    assign mem.mem_we      = we_q;
    assign mem.mem_wdata_x = wx_q;
    assign mem.mem_wdata_y = wy_q;
    assign upd_grant       = grant_q;
    assign en_snake_body   = en_q;
    assign snake_body_x    = bx_q;
    assign snake_body_y    = by_q;
    assign stream_busy     = busy_q;
    assign frame_done      = done_q;

endmodule

// File: tb/tb_snake_body_streamer.sv
// Scoreboard bench for snake_body_streamer: stimulus pushes expected entries/pulses/writes, a monitor pops and compares.
`ifndef PIXEL_DISPLAY_BIT
`define PIXEL_DISPLAY_BIT 9
`endif

module tb_snake_body_streamer;

    logic                        clock_25 = 1'b0;
    logic                        reset = 1'b1;
    logic [`PIXEL_DISPLAY_BIT:0] X = '0;
    logic [`PIXEL_DISPLAY_BIT:0] Y = '0;
    logic [6:0]                  snake_length = '0;
    logic                        upd_req = 1'b0;
    logic [6:0]                  upd_addr = '0;
    logic [6:0]                  upd_x = '0;
    logic [6:0]                  upd_y = '0;
    logic                        upd_grant;
    logic                        en_snake_body;
    logic [6:0]                  snake_body_x;
    logic [6:0]                  snake_body_y;
    logic                        stream_busy;
    logic                        frame_done;

    snake_body_streamer_if #(.ADDR_W(7), .COORD_W(7)) mem ();

    snake_body_streamer #(.ADDR_W(7), .COORD_W(7), .STREAM_LINE(449)) dut (
        .clock_25      (clock_25),
        .reset         (reset),
        .X             (X),
        .Y             (Y),
        .snake_length  (snake_length),
        .upd_req       (upd_req),
        .upd_addr      (upd_addr),
        .upd_x         (upd_x),
        .upd_y         (upd_y),
        .upd_grant     (upd_grant),
        .mem           (mem.master),
        .en_snake_body (en_snake_body),
        .snake_body_x  (snake_body_x),
        .snake_body_y  (snake_body_y),
        .stream_busy   (stream_busy),
        .frame_done    (frame_done)
    );

    always #20 clock_25 = ~clock_25;

    // Body RAM: synchronous read, data valid the cycle after the address
    logic [6:0] ram_x [128];
    logic [6:0] ram_y [128];
    initial begin
        for (int k = 0; k < 128; k++) begin
            ram_x[k] = 7'(k);
            ram_y[k] = 7'(k + 10);
        end
    end
    always @(posedge clock_25) begin
        if (mem.mem_we) begin
            ram_x[mem.mem_addr] <= mem.mem_wdata_x;
            ram_y[mem.mem_addr] <= mem.mem_wdata_y;
        end
        mem.mem_rdata_x <= ram_x[mem.mem_addr];
        mem.mem_rdata_y <= ram_y[mem.mem_addr];
    end

    int cyc = 0;
    always @(posedge clock_25) cyc <= cyc + 1;

    typedef struct { int cyc; int x; int y; } ent_t;
    typedef struct { int cyc; int addr; int x; int y; } wr_t;
    ent_t ent_q[$];
    int   fd_q[$];
    wr_t  wr_q[$];

    int exp_x [128];
    int exp_y [128];
    int total = 0;
    int bad = 0;

    function automatic void check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d (cycle %0d)", name, got, want, cyc);
        end
    endfunction

    // Monitor
    always @(negedge clock_25) begin
        if (en_snake_body) begin
            if (ent_q.size() == 0) check("unexpected_entry", 1, 0);
            else begin
                ent_t e;
                e = ent_q.pop_front();
                check("entry_cycle", cyc, e.cyc);
                check("entry_x", int'(snake_body_x), e.x);
                check("entry_y", int'(snake_body_y), e.y);
            end
        end else begin
            check("idle_body_x_zero", int'(snake_body_x), 0);
            check("idle_body_y_zero", int'(snake_body_y), 0);
        end
        if (frame_done) begin
            if (fd_q.size() == 0) check("unexpected_frame_done", 1, 0);
            else check("frame_done_cycle", cyc, fd_q.pop_front());
        end
        if (mem.mem_we) begin
            check("we_not_busy", int'(stream_busy), 0);
            check("we_with_grant", int'(upd_grant), 1);
            if (wr_q.size() == 0) check("unexpected_write", 1, 0);
            else begin
                wr_t w;
                w = wr_q.pop_front();
                check("write_cycle", cyc, w.cyc);
                check("write_addr", int'(mem.mem_addr), w.addr);
                check("write_x", int'(mem.mem_wdata_x), w.x);
                check("write_y", int'(mem.mem_wdata_y), w.y);
            end
        end else if (upd_grant) begin
            check("grant_without_we", 1, 0);
        end
    end

    task automatic trig(input int len, output int t);
        @(negedge clock_25);
        snake_length = 7'(len);
        X = 10'd799;
        Y = 10'd449;
        t = cyc;
        for (int i = 0; i < len; i++) ent_q.push_back('{t + 3 + i, exp_x[i], exp_y[i]});
        fd_q.push_back((len == 0) ? t + 1 : t + 3 + len);
        @(negedge clock_25);
        X = '0;
        Y = '0;
    endtask

    task automatic write_req(input int a, input int wx, input int wy);
        int g;
        @(negedge clock_25);
        upd_req  = 1'b1;
        upd_addr = 7'(a);
        upd_x    = 7'(wx);
        upd_y    = 7'(wy);
        g = cyc;
        wr_q.push_back('{g + 1, a, wx, wy});
        @(negedge clock_25);
        // still requesting in the grant cycle: the back-to-back guard must hold off a second write
        @(negedge clock_25);
        upd_req = 1'b0;
        exp_x[a] = wx;
        exp_y[a] = wy;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock_25);
    endtask

    initial begin
        int t;
        int seen;
        for (int k = 0; k < 128; k++) begin
            exp_x[k] = k;
            exp_y[k] = k + 10;
        end

        // Reset state
        idle(3);
        check("rst_mem_addr", int'(mem.mem_addr), 0);
        check("rst_mem_we", int'(mem.mem_we), 0);
        check("rst_wdata_x", int'(mem.mem_wdata_x), 0);
        check("rst_wdata_y", int'(mem.mem_wdata_y), 0);
        check("rst_en", int'(en_snake_body), 0);
        check("rst_grant", int'(upd_grant), 0);
        check("rst_busy", int'(stream_busy), 0);
        check("rst_frame_done", int'(frame_done), 0);
        reset = 1'b0;
        idle(2);

        // len=5 stream, plus a second trigger mid-stream that must be ignored
        trig(5, t);
        check("len5_busy_t1", int'(stream_busy), 1);
        check("len5_addr_t1", int'(mem.mem_addr), 0);
        @(negedge clock_25);
        X = 10'd799;
        Y = 10'd449;
        @(negedge clock_25);
        X = '0;
        Y = '0;
        idle(10);

        // len=0: straight to DONE, busy only in T+1
        trig(0, t);
        check("len0_busy_t1", int'(stream_busy), 1);
        @(negedge clock_25);
        check("len0_busy_t2", int'(stream_busy), 0);
        idle(4);

        // Writes in IDLE, one beyond the stream length
        write_req(3, 20, 30);
        write_req(50, 5, 6);
        idle(2);
        trig(5, t);
        idle(10);

        // Trigger and request together: stream wins, write lands the cycle after frame_done
        @(negedge clock_25);
        snake_length = 7'd5;
        X = 10'd799;
        Y = 10'd449;
        upd_req  = 1'b1;
        upd_addr = 7'd7;
        upd_x    = 7'd99;
        upd_y    = 7'd98;
        t = cyc;
        for (int i = 0; i < 5; i++) ent_q.push_back('{t + 3 + i, exp_x[i], exp_y[i]});
        fd_q.push_back(t + 8);
        wr_q.push_back('{t + 9, 7, 99, 98});
        @(negedge clock_25);
        X = '0;
        Y = '0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (upd_grant) begin
                seen = 1;
                break;
            end
            @(negedge clock_25);
        end
        check("pending_req_granted", seen, 1);
        upd_req = 1'b0;
        exp_x[7] = 99;
        exp_y[7] = 98;
        idle(3);
        trig(8, t);
        idle(13);

        // snake_length changes mid-stream: latched 4 governs
        trig(4, t);
        snake_length = 7'd9;
        idle(10);

        // Reset in T+5 of a len=10 stream
        @(negedge clock_25);
        snake_length = 7'd10;
        X = 10'd799;
        Y = 10'd449;
        t = cyc;
        for (int i = 0; i < 3; i++) ent_q.push_back('{t + 3 + i, exp_x[i], exp_y[i]});
        @(negedge clock_25);
        X = '0;
        Y = '0;
        idle(4);
        reset = 1'b1;
        @(negedge clock_25);
        check("abort_en", int'(en_snake_body), 0);
        check("abort_busy", int'(stream_busy), 0);
        check("abort_addr", int'(mem.mem_addr), 0);
        check("abort_we", int'(mem.mem_we), 0);
        check("abort_frame_done", int'(frame_done), 0);
        reset = 1'b0;
        idle(15);
        trig(10, t);
        idle(16);

        check("entries_left", ent_q.size(), 0);
        check("frame_done_left", fd_q.size(), 0);
        check("writes_left", wr_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/snake_body_streamer.md
SNAKE_BODY_STREAMER -- requirements
Module: snake_body_streamer

Interface
REQ-001 SHALL have parameter ADDR_W, default 7: body-RAM address width; max snake length is 2^ADDR_W-1.
REQ-002 SHALL have parameter COORD_W, default 7: block-coordinate width.
REQ-003 SHALL have parameter STREAM_LINE, default 449: first line after the game area; the stream starts on this line.
REQ-004 SHALL have port clock_25, input, 1: 25 MHz pixel clock; the only clock.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have ports X and Y, input, `PIXEL_DISPLAY_BIT+1 each: screen counters; X wraps at 799.
REQ-007 SHALL have port snake_length, input, ADDR_W: number of body entries to stream.
REQ-008 SHALL have ports upd_req, upd_addr, upd_x and upd_y, input, 1/ADDR_W/COORD_W/COORD_W: game-logic write request to body RAM.
REQ-009 SHALL have port upd_grant, output, 1: one-cycle pulse in the cycle the requested write is issued.
REQ-010 SHALL have ports mem_addr and mem_we, output, ADDR_W/1: body-RAM port control.
REQ-011 SHALL have ports mem_wdata_x and mem_wdata_y, output, COORD_W each: body-RAM write data.
REQ-012 SHALL have ports mem_rdata_x and mem_rdata_y, input, COORD_W each: body-RAM read data, valid the cycle after mem_addr is presented.
REQ-013 SHALL have port en_snake_body, output, 1: high while streamed entries are valid toward the renderer.
REQ-014 SHALL have ports snake_body_x and snake_body_y, output, COORD_W each: streamed body coordinates.
REQ-015 SHALL have port stream_busy, output, 1: high in any state other than IDLE.
REQ-016 SHALL have port frame_done, output, 1: one-cycle pulse when a stream completes.

Function
REQ-017 SHALL have FSM states IDLE, READ, DRAIN and DONE; all outputs SHALL be registered.
REQ-018 Trigger SHALL be X==799 && Y==STREAM_LINE, sampled in cycle T; the trigger is honoured only in IDLE.
REQ-019 On trigger, the block SHALL latch len=snake_length and go to READ with mem_addr=0 and mem_we=0 in cycle T+1.
REQ-020 In READ, mem_addr SHALL increment by 1 per cycle through len-1, then the FSM goes to DRAIN.
REQ-021 Entry i SHALL appear on snake_body_x/y with en_snake_body=1 in cycle T+3+i, with no gaps, in order 0..len-1.
REQ-022 DRAIN SHALL last until the last entry is presented; the FSM then goes to DONE.
REQ-023 DONE SHALL last one cycle: frame_done=1 and en_snake_body=0 in cycle T+3+len, then the FSM returns to IDLE.
REQ-024 If len==0, the FSM SHALL go IDLE->DONE directly: no en_snake_body, frame_done pulse in cycle T+1.
REQ-025 Changes to snake_length during the stream SHALL be ignored; the latched len governs.
REQ-026 A trigger while not in IDLE SHALL be ignored.
REQ-027 When en_snake_body=0, snake_body_x/y SHALL hold 0.
REQ-028 Arbitration: the stream has absolute priority; upd_req SHALL be served only in IDLE in a cycle with no trigger.
REQ-029 Granted write: in the following cycle, mem_we=1, mem_addr=upd_addr, mem_wdata=upd_x/upd_y and upd_grant=1, all for one cycle.
REQ-030 Simultaneous trigger and upd_req in IDLE: the stream SHALL win; the request stays pending, is not dropped, and is served after DONE.
REQ-031 No grant SHALL be issued in the cycle immediately after a grant; the requester drops or changes upd_req after seeing upd_grant (max 1 write per 2 cycles).
REQ-032 mem_we SHALL never be 1 while stream_busy=1.
REQ-033 upd_addr >= len SHALL be legal and written unchanged; no range check.

Reset
REQ-034 With reset=1 at a clock edge, the FSM SHALL go to IDLE and all outputs SHALL be 0 (mem_addr, mem_we, mem_wdata_x/y, en_snake_body, snake_body_x/y, upd_grant, stream_busy, frame_done); latched len SHALL be 0.
REQ-035 Reset mid-stream SHALL abort the stream with no frame_done; the next trigger after release SHALL start a fresh stream from address 0.

Verification
REQ-036 len=5, trigger at T, RAM entry k=(k,k+10) -> en_snake_body high in cycles T+3..T+7 with (0,10)..(4,14); frame_done in T+8.
REQ-037 len=0, trigger -> en_snake_body never high; frame_done in T+1; stream_busy high only in T+1.
REQ-038 upd_req with addr=3, (20,30) in IDLE -> next cycle mem_we=1, mem_addr=3, wdata=(20,30), upd_grant=1; a following trigger streams (20,30) as entry 3.
REQ-039 upd_req asserted in the trigger cycle and held -> no mem_we during the stream; grant in the cycle after frame_done.
REQ-040 len=4 latched, snake_length changed to 9 mid-stream -> exactly 4 entries streamed.
REQ-041 reset=1 in cycle T+5 of a len=10 stream -> all outputs 0 the next cycle, no frame_done; the next trigger streams from entry 0.
